// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN result-path types, sizes and the relu helper
package cnn_pkg;
    localparam int CNN_RES_W = 9;
    localparam int CNN_N_OUT = 16;
    localparam int CNN_IDX_W = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic logic signed [CNN_RES_W-1:0] relu(input logic signed [CNN_RES_W-1:0] x);
        return x[CNN_RES_W-1] ? '0 : x;
    endfunction
endpackage

// File: rtl/cnn_result_serializer_if.sv
// rtl/cnn_result_serializer_if.sv - result word stream toward the host readback path
interface cnn_result_serializer_if #(
    parameter int W     = cnn_pkg::CNN_RES_W,
    parameter int IDX_W = cnn_pkg::CNN_IDX_W
);
    logic [W-1:0]     m_data;
    logic [IDX_W-1:0] m_idx;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;

    modport master (output m_data, m_idx, m_valid, m_last, input m_ready);
    modport slave  (input m_data, m_idx, m_valid, m_last, output m_ready);
endinterface

// File: rtl/cnn_sat_counter.sv
// rtl/cnn_sat_counter.sv - generic saturating up-counter with synchronous reset
module cnn_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/cnn_result_serializer.sv
// rtl/cnn_result_serializer.sv - captures a 4x4 array result set and streams it one word per beat
module cnn_result_serializer
    import cnn_pkg::*;
#(
    parameter int N_OUT = CNN_N_OUT,
    parameter int W     = CNN_RES_W,
    parameter bit RELU  = 1'b0,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cap_stb,
    input  logic [N_OUT*W-1:0]   y_in,
    cnn_result_serializer_if.master m_if,
    output logic                 busy,
    output logic [CNT_W-1:0]     drop_cnt
);
    localparam int               IDX_W    = $clog2(N_OUT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [W-1:0]     buf_q [N_OUT];
    logic [W-1:0]     cap_word [N_OUT];

    logic fire;
    logic last_fire;
    logic accept;
    logic drop;

    assign fire      = (state_q == SEND) && m_if.m_ready;
    assign last_fire = fire && (idx_q == LAST_IDX);
    assign accept    = cap_stb && ((state_q == IDLE) || last_fire);
    assign drop      = cap_stb && !accept;

    for (genvar k = 0; k < N_OUT; k++) begin : g_cap
        logic [W-1:0] raw;
        assign raw = y_in[k*W +: W];
        if (RELU && (W == CNN_RES_W)) begin : g_relu_pkg
            assign cap_word[k] = relu(raw);
        end else if (RELU) begin : g_relu_gen
            assign cap_word[k] = raw[W-1] ? '0 : raw;
        end else begin : g_pass
            assign cap_word[k] = raw;
        end
    end

    // Buffer contents are don't-care after reset, so it carries no reset term.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < N_OUT; k++) begin
                buf_q[k] <= cap_word[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cap_stb) begin
                        state_q <= SEND;
                        idx_q   <= '0;
                    end
                end
                SEND: begin
                    if (fire) begin
                        if (idx_q == LAST_IDX) begin
                            // A capture on the final beat keeps SEND with no bubble.
                            idx_q   <= '0;
                            state_q <= accept ? SEND : IDLE;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    assign m_if.m_valid = (state_q == SEND);
    assign m_if.m_idx   = idx_q;
    assign m_if.m_last  = (state_q == SEND) && (idx_q == LAST_IDX);
    assign m_if.m_data  = (state_q == SEND) ? buf_q[idx_q] : '0;
    assign busy         = (state_q == SEND);

    cnn_sat_counter #(
        .W(CNT_W)
    ) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (drop),
        .cnt_o (drop_cnt)
    );
endmodule

// File: tb/tb_cnn_result_serializer.sv
// tb/tb_cnn_result_serializer.sv - scoreboard bench for cnn_result_serializer
module tb_cnn_result_serializer;
    typedef struct {
        logic [8:0] data;
        logic [3:0] idx;
        logic       last;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cap = 1'b0;
    logic         rdy = 1'b0;
    logic         sel = 1'b0;
    logic [143:0] y   = '0;

    logic         cap0, cap1;
    logic         busy0, busy1;
    logic [7:0]   drop0, drop1;

    logic [8:0]   o_data;
    logic [3:0]   o_idx;
    logic         o_valid, o_last, o_busy;
    logic [7:0]   o_drop;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    exp_drop = 0;
    beat_t sb[$];

    cnn_result_serializer_if #(.W(9), .IDX_W(4)) if0 ();
    cnn_result_serializer_if #(.W(9), .IDX_W(4)) if1 ();

    assign cap0        = cap & ~sel;
    assign cap1        = cap & sel;
    assign if0.m_ready = rdy & ~sel;
    assign if1.m_ready = rdy & sel;

    assign o_data  = sel ? if1.m_data  : if0.m_data;
    assign o_idx   = sel ? if1.m_idx   : if0.m_idx;
    assign o_valid = sel ? if1.m_valid : if0.m_valid;
    assign o_last  = sel ? if1.m_last  : if0.m_last;
    assign o_busy  = sel ? busy1 : busy0;
    assign o_drop  = sel ? drop1 : drop0;

    cnn_result_serializer #(.N_OUT(16), .W(9), .RELU(1'b0), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .cap_stb(cap0), .y_in(y), .m_if(if0), .busy(busy0), .drop_cnt(drop0)
    );

    cnn_result_serializer #(.N_OUT(16), .W(9), .RELU(1'b1), .CNT_W(8)) dut_relu (
        .clk(clk), .rst(rst), .cap_stb(cap1), .y_in(y), .m_if(if1), .busy(busy1), .drop_cnt(drop1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_set(input logic [143:0] yy, input bit relu);
        beat_t b;
        for (int k = 0; k < 16; k++) begin
            b.data = yy[k*9 +: 9];
            if (relu && b.data[8]) b.data = 9'd0;
            b.idx  = 4'(k);
            b.last = (k == 15);
            sb.push_back(b);
        end
    endtask

    task automatic load_ramp();
        for (int k = 0; k < 16; k++) y[k*9 +: 9] = 9'(k - 8);
    endtask

    task automatic load_all(input logic [8:0] v);
        for (int k = 0; k < 16; k++) y[k*9 +: 9] = v;
    endtask

    task automatic capture();
        n_cmp++;
        if (o_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL pre_capture_valid: got %b want 0", o_valid);
        end
        cap = 1'b1;
        tick();
        cap = 1'b0;
    endtask

    // mode 0: ready always high; mode 1: ready pattern 1,0,0 repeating
    task automatic drain(input int mode, input int budget, output int cycles);
        int c = 0;
        while (sb.size() > 0 && c < budget) begin
            rdy = (mode == 0) ? 1'b1 : ((c % 3) == 0);
            n_cmp++;
            if (o_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL beat_valid: got %b want 1 (expect idx %0d)", o_valid, sb[0].idx);
            end else if (o_data !== sb[0].data || o_idx !== sb[0].idx || o_last !== sb[0].last) begin
                n_bad++;
                $display("FAIL beat: got data %0h idx %0d last %b want data %0h idx %0d last %b",
                         o_data, o_idx, o_last, sb[0].data, sb[0].idx, sb[0].last);
            end
            if (o_valid === 1'b1 && rdy) void'(sb.pop_front());
            tick();
            c++;
        end
        rdy = 1'b0;
        cycles = c;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain_timeout: got %0d left want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_idle(input string tag);
        n_cmp++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_data !== 9'd0 || o_last !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_idle: got valid %b busy %b data %0h last %b want 0 0 0 0",
                     tag, o_valid, o_busy, o_data, o_last);
        end
        n_cmp++;
        if (o_drop !== 8'(exp_drop)) begin
            n_bad++;
            $display("FAIL %s_drop_cnt: got %0d want %0d", tag, o_drop, exp_drop);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_drop = 0;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check_idle("reset");
            n_cmp++;
            if (o_idx !== 4'd0) begin
                n_bad++;
                $display("FAIL reset_idx: got %0d want 0", o_idx);
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_basic();
        int c;
        sel = 1'b0;
        load_ramp();
        push_set(y, 1'b0);
        capture();
        drain(0, 40, c);
        n_cmp++;
        if (c != 16) begin
            n_bad++;
            $display("FAIL basic_cycles: got %0d want 16", c);
        end
        check_idle("basic");
    endtask

    task automatic test_backpressure();
        int c;
        sel = 1'b0;
        load_ramp();
        push_set(y, 1'b0);
        capture();
        drain(1, 100, c);
        n_cmp++;
        if (c != 46) begin
            n_bad++;
            $display("FAIL bp_cycles: got %0d want 46", c);
        end
        check_idle("bp");
    endtask

    task automatic test_relu();
        int c;
        sel = 1'b1;
        load_all(9'h1FB);
        y[0 +: 9]  = 9'h100;
        y[9 +: 9]  = 9'h1FF;
        y[18 +: 9] = 9'h000;
        y[27 +: 9] = 9'h0FF;
        push_set(y, 1'b1);
        capture();
        drain(0, 40, c);
        check_idle("relu");
        sel = 1'b0;
    endtask

    task automatic test_back_to_back();
        int  c = 0;
        int  n = 0;
        logic [143:0] set_b;
        sel = 1'b0;
        load_ramp();
        push_set(y, 1'b0);
        capture();
        load_all(9'd3);
        set_b = y;
        while (sb.size() > 0 && c < 60) begin
            cap = 1'b0;
            rdy = 1'b1;
            if (n == 14) begin
                load_all(9'd5);
                cap = 1'b1;
                exp_drop++;
            end else if (n == 15) begin
                y   = set_b;
                cap = 1'b1;
            end
            n_cmp++;
            if (o_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL b2b_valid: got %b want 1 at beat %0d", o_valid, n);
            end else if (o_data !== sb[0].data || o_idx !== sb[0].idx || o_last !== sb[0].last) begin
                n_bad++;
                $display("FAIL b2b_beat: got data %0h idx %0d last %b want data %0h idx %0d last %b",
                         o_data, o_idx, o_last, sb[0].data, sb[0].idx, sb[0].last);
            end
            if (o_valid === 1'b1) begin
                void'(sb.pop_front());
                if (n == 15) push_set(set_b, 1'b0);
                n++;
            end
            tick();
            c++;
        end
        cap = 1'b0;
        rdy = 1'b0;
        n_cmp++;
        if (n != 32 || c != 32) begin
            n_bad++;
            $display("FAIL b2b_count: got beats %0d cycles %0d want 32 32", n, c);
            sb.delete();
        end
        check_idle("b2b");
    endtask

    task automatic test_drop_sat();
        int c;
        sel = 1'b0;
        load_ramp();
        push_set(y, 1'b0);
        capture();
        load_all(9'h0AA);
        rdy = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cap = 1'b1;
            tick();
            if (exp_drop < 255) exp_drop++;
            if (i == 9) begin
                n_cmp++;
                if (o_drop !== 8'(exp_drop)) begin
                    n_bad++;
                    $display("FAIL drop_mid: got %0d want %0d", o_drop, exp_drop);
                end
            end
        end
        cap = 1'b0;
        n_cmp++;
        if (o_drop !== 8'd255) begin
            n_bad++;
            $display("FAIL drop_sat: got %0d want 255", o_drop);
        end
        drain(0, 40, c);
        check_idle("drop");
    endtask

    task automatic test_reset_mid();
        int c;
        sel = 1'b0;
        load_ramp();
        push_set(y, 1'b0);
        capture();
        rdy = 1'b1;
        for (int i = 0; i < 7; i++) begin
            n_cmp++;
            if (o_valid !== 1'b1 || o_data !== sb[0].data || o_idx !== sb[0].idx) begin
                n_bad++;
                $display("FAIL rstmid_beat: got valid %b data %0h idx %0d want 1 %0h %0d",
                         o_valid, o_data, o_idx, sb[0].data, sb[0].idx);
            end
            void'(sb.pop_front());
            tick();
        end
        n_cmp++;
        if (o_idx !== 4'd7) begin
            n_bad++;
            $display("FAIL rstmid_at7: got %0d want 7", o_idx);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        exp_drop = 0;
        check_idle("rstmid");
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (o_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL rstmid_quiet: got %b want 0", o_valid);
            end
        end
        rdy = 1'b0;
        load_all(9'h1F0);
        push_set(y, 1'b0);
        capture();
        drain(0, 40, c);
        check_idle("restart");
    endtask

    initial begin
        tick();
        test_reset();
        test_basic();
        test_backpressure();
        test_relu();
        test_back_to_back();
        test_drop_sat();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
